// File: rtl/muldiv_unit_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
// Also carries the M-extension funct3/funct7 codes used by the decoder.
package muldiv_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [6:0] OPC_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op1_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op2_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_mul_high(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if;
    logic        start_in;
    logic [2:0]  op_in;
    logic [31:0] data_1_in;
    logic [31:0] data_2_in;
    logic        flush_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] result_out;

    modport master (
        output start_in, op_in, data_1_in, data_2_in, flush_in,
        input  busy_out, done_out, result_out
    );

    modport slave (
        input  start_in, op_in, data_1_in, data_2_in, flush_in,
        output busy_out, done_out, result_out
    );
endinterface

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement, used for operand magnitudes and result sign fix-up.
module muldiv_unit_negate #(
    parameter int WIDTH = 64
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    // Negate when requested, pass through otherwise.
    always_comb begin
        if (neg_i) begin
            data_o = (~data_i) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add / restoring divide, one bit per cycle.
// Division by zero and signed overflow complete on the accept edge without iterating.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  md
);

    md_state_e   state_q;
    md_op_e      op_q;
    logic [63:0] opa_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic [31:0] result_q;
    logic [5:0]  count_q;
    logic        res_neg_q;
    logic        busy_q;
    logic        done_q;

    md_op_e      op_s;
    logic        sign1_s;
    logic        sign2_s;
    logic [31:0] mag1_s;
    logic [31:0] mag2_s;
    logic        div_zero_s;
    logic        ovf_s;
    logic        res_neg_s;
    logic [31:0] fast_res_s;
    logic [63:0] acc_step_s;
    logic [63:0] opa_step_s;
    logic [31:0] opb_step_s;
    logic [32:0] rem_sh_s;
    logic [32:0] rem_sub_s;
    logic [63:0] fix_in_s;
    logic [63:0] fix_out_s;
    logic [31:0] fin_res_s;

    assign op_s    = md_op_e'(md.op_in);
    assign sign1_s = op1_signed(op_s) & md.data_1_in[31];
    assign sign2_s = op2_signed(op_s) & md.data_2_in[31];

    muldiv_unit_negate #(.WIDTH(32)) u_neg_op1 (
        .neg_i  (sign1_s),
        .data_i (md.data_1_in),
        .data_o (mag1_s)
    );

    muldiv_unit_negate #(.WIDTH(32)) u_neg_op2 (
        .neg_i  (sign2_s),
        .data_i (md.data_2_in),
        .data_o (mag2_s)
    );

    assign div_zero_s = is_div(op_s) & (md.data_2_in == 32'd0);
    assign ovf_s      = ((op_s == MD_DIV) || (op_s == MD_REM)) &
                        (md.data_1_in == 32'h8000_0000) & (md.data_2_in == 32'hFFFF_FFFF);

    // Result sign rule and short-circuit results for the accept edge.
    always_comb begin
        res_neg_s  = sign1_s ^ sign2_s;
        fast_res_s = 32'd0;
        case (op_s)
            MD_REM, MD_REMU: res_neg_s = sign1_s;
            default:         res_neg_s = sign1_s ^ sign2_s;
        endcase
        if (div_zero_s) begin
            fast_res_s = op_s[1] ? md.data_1_in : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            fast_res_s = op_s[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            fast_res_s = 32'd0;
        end
    end

    // One iteration: acc_q is the product for multiply, {remainder, quotient} for divide.
    always_comb begin
        acc_step_s = acc_q;
        opa_step_s = {opa_q[62:0], 1'b0};
        opb_step_s = opb_q;
        rem_sh_s   = 33'd0;
        rem_sub_s  = 33'd0;
        if (is_div(op_q)) begin
            rem_sh_s  = {acc_q[63:32], opa_q[31]};
            rem_sub_s = rem_sh_s - {1'b0, opb_q};
            if (!rem_sub_s[32]) begin
                acc_step_s = {rem_sub_s[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_step_s = {rem_sh_s[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            acc_step_s = acc_q + (opb_q[0] ? opa_q : 64'd0);
            opb_step_s = {1'b0, opb_q[31:1]};
        end
    end

    // Pick the raw magnitude to sign-correct on the final iteration.
    always_comb begin
        fix_in_s = acc_step_s;
        case (op_q)
            MD_DIV, MD_DIVU: fix_in_s = {32'd0, acc_step_s[31:0]};
            MD_REM, MD_REMU: fix_in_s = {32'd0, acc_step_s[63:32]};
            default:         fix_in_s = acc_step_s;
        endcase
    end

    muldiv_unit_negate #(.WIDTH(64)) u_neg_res (
        .neg_i  (res_neg_q),
        .data_i (fix_in_s),
        .data_o (fix_out_s)
    );

    assign fin_res_s = is_mul_high(op_q) ? fix_out_s[63:32] : fix_out_s[31:0];

    // Control FSM and datapath registers; flush overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MUL;
            opa_q     <= 64'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            result_q  <= 32'd0;
            count_q   <= 6'd0;
            res_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (md.flush_in) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (md.start_in) begin
                        op_q      <= op_s;
                        res_neg_q <= res_neg_s;
                        opa_q     <= {32'd0, mag1_s};
                        opb_q     <= mag2_s;
                        acc_q     <= 64'd0;
                        count_q   <= 6'd0;
                        if (div_zero_s || ovf_s) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= fast_res_s;
                        end else begin
                            state_q <= ST_CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_q   <= acc_step_s;
                    opa_q   <= opa_step_s;
                    opb_q   <= opb_step_s;
                    count_q <= count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fin_res_s;
                    end else begin
                        state_q <= ST_CALC;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy_out   = busy_q;
    assign md.done_out   = done_q;
    assign md.result_out = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed RV32M results and control timing.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    muldiv_unit_if md_if ();

    muldiv_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a start at the current falling edge; returns at the falling edge of cycle 1.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_if.start_in  = 1'b1;
        md_if.op_in     = op;
        md_if.data_1_in = a;
        md_if.data_2_in = b;
        @(negedge clk);
        md_if.start_in  = 1'b0;
        md_if.op_in     = 3'($urandom_range(0, 7));
        md_if.data_1_in = $urandom;
        md_if.data_2_in = $urandom;
    endtask

    // From cycle 1: expect busy in 1..32, done only in 33; optional stray start at cycle inj.
    task automatic wait_calc(input string tag, input logic [31:0] exp, input int inj);
        int bad;
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (md_if.busy_out !== 1'b1 || md_if.done_out !== 1'b0) bad++;
            md_if.start_in = (i == inj);
            if (i == inj) begin
                md_if.op_in     = MD_DIV;
                md_if.data_2_in = 32'd0;
            end
            @(negedge clk);
        end
        md_if.start_in = 1'b0;
        check_val({tag, "_busy"}, 32'(bad), 32'd0);
        check_val({tag, "_done"}, {31'd0, md_if.done_out}, 32'd1);
        check_val({tag, "_res"}, md_if.result_out, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast);
        @(negedge clk);
        start_op(op, a, b);
        if (fast) begin
            check_val({tag, "_done"}, {31'd0, md_if.done_out}, 32'd1);
            check_val({tag, "_busy"}, {31'd0, md_if.busy_out}, 32'd0);
            check_val({tag, "_res"}, md_if.result_out, exp);
        end else begin
            wait_calc(tag, exp, 0);
        end
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        md_if.start_in  = 1'b0;
        md_if.flush_in  = 1'b0;
        md_if.op_in     = 3'd0;
        md_if.data_1_in = 32'd0;
        md_if.data_2_in = 32'd0;
        #2;
        check_val("rst_busy", {31'd0, md_if.busy_out}, 32'd0);
        check_val("rst_done", {31'd0, md_if.done_out}, 32'd0);
        check_val("rst_res", md_if.result_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul", MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("div", MD_DIV, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0);
        run_op("rem", MD_REM, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0);
        run_op("divu", MD_DIVU, 32'hFFFF_FFEC, 32'h0000_0003, 32'h5555_554E, 1'b0);
        run_op("remu", MD_REMU, 32'hFFFF_FFEC, 32'h0000_0003, 32'h0000_0002, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_op("div_z", MD_DIV, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_z", MD_REMU, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1);

        // Flush in cycle 10: no done, result keeps 0x1234.
        @(negedge clk);
        start_op(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        for (int i = 1; i < 10; i++) @(negedge clk);
        check_val("fl_busy_pre", {31'd0, md_if.busy_out}, 32'd1);
        md_if.flush_in = 1'b1;
        @(negedge clk);
        md_if.flush_in = 1'b0;
        check_val("fl_busy_post", {31'd0, md_if.busy_out}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_if.done_out !== 1'b0 || md_if.busy_out !== 1'b0) cnt++;
            @(negedge clk);
        end
        check_val("fl_quiet", 32'(cnt), 32'd0);
        check_val("fl_res", md_if.result_out, 32'h0000_1234);

        // Flush and start together: start dropped.
        md_if.flush_in = 1'b1;
        start_op(MD_DIVU, 32'd100, 32'd7);
        md_if.flush_in = 1'b0;
        check_val("flst_busy", {31'd0, md_if.busy_out}, 32'd0);
        check_val("flst_done", {31'd0, md_if.done_out}, 32'd0);

        // Back-to-back with a stray start ignored during CALC.
        @(negedge clk);
        start_op(MD_DIVU, 32'd100, 32'd7);
        wait_calc("b2b_a", 32'h0000_000E, 8);
        start_op(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        wait_calc("b2b_b", 32'hFFFF_FFEB, 0);
        @(negedge clk);
        check_val("b2b_done_drop", {31'd0, md_if.done_out}, 32'd0);

        // Asynchronous reset mid-CALC clears outputs immediately.
        start_op(MD_MULHU, 32'h0000_0006, 32'h0000_0007);
        for (int i = 1; i < 10; i++) @(negedge clk);
        check_val("ar_busy_pre", {31'd0, md_if.busy_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_busy", {31'd0, md_if.busy_out}, 32'd0);
        check_val("ar_done", {31'd0, md_if.done_out}, 32'd0);
        check_val("ar_res", md_if.result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", MD_MUL, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
